x2050mvw: RTL

X2050MVW -- requirements
Module: x2050mvw

---
 rtl/x2050_pkg.sv | 36 +++
 rtl/x2050mvlane.sv | 64 ++++++
 rtl/x2050mvw.sv | 129 ++++++++++++
 3 files changed

// File: rtl/x2050_pkg.sv
// x2050 mover shared definitions: function codes, nibble source selectors, WFN stat.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package x2050_pkg;

  // Mover function codes held in a WFN register.
  localparam logic [2:0] WFN_SWAP  = 3'd0;  // U nibble swap
  localparam logic [2:0] WFN_OR    = 3'd1;  // U | V
  localparam logic [2:0] WFN_AND   = 3'd2;  // U & V
  localparam logic [2:0] WFN_XOR   = 3'd3;  // U ^ V
  localparam logic [2:0] WFN_PASSU = 3'd4;  // U
  localparam logic [2:0] WFN_UHVL  = 3'd5;  // U high : V low
  localparam logic [2:0] WFN_VHUL  = 3'd6;  // V high : U low
  localparam logic [2:0] WFN_NOTU  = 3'd7;  // ~U

  // Left/right nibble source selectors.
  localparam logic [1:0] SRC_EMIX = 2'd0;
  localparam logic [1:0] SRC_U    = 2'd1;
  localparam logic [1:0] SRC_V    = 2'd2;
  localparam logic [1:0] SRC_FN   = 2'd3;

  // Special-stat value that loads the active WFN register.
  localparam logic [5:0] SS_WFN = 6'd38;

  // Bit of PSW AMWP selecting ASCII mode.
  localparam int AMWP_ASCII_BIT = 3;

  // E-mixin: in ASCII mode the emit nibble is remapped (EBCDIC zone F -> ASCII zone 5).
  function automatic logic [3:0] e_mixin(input logic [3:0] e, input logic ascii);
    if (ascii) begin
      return {~e[3] | ~e[1], e[1] | ~e[2], ~e[1], e[0]};
    end
    return e;
  endfunction

endpackage

// File: rtl/x2050mvlane.sv
// Single byte lane of the x2050 mover: function unit, nibble selection, edit status.
// Latency: combinational.
// Backpressure: none; the top module owns registers and handshake.
// Ports: i_u/i_v operand bytes, i_fn function code, i_ul/i_ur nibble sources,
//        i_emix mixed emit nibble, o_w mover byte, o_stat edit status (bit0, bit1).
module x2050mvlane
  import x2050_pkg::*;
(
  input  logic [7:0] i_u,
  input  logic [7:0] i_v,
  input  logic [2:0] i_fn,
  input  logic [1:0] i_ul,
  input  logic [1:0] i_ur,
  input  logic [3:0] i_emix,
  output logic [7:0] o_w,
  output logic [1:0] o_stat
);

  logic [7:0] w_fn;
  logic [3:0] w_hi;
  logic [3:0] w_lo;

  always_comb begin
    w_fn = ~i_u;
    case (i_fn)
      WFN_SWAP:  w_fn = {i_u[3:0], i_u[7:4]};
      WFN_OR:    w_fn = i_u | i_v;
      WFN_AND:   w_fn = i_u & i_v;
      WFN_XOR:   w_fn = i_u ^ i_v;
      WFN_PASSU: w_fn = i_u;
      WFN_UHVL:  w_fn = {i_u[7:4], i_v[3:0]};
      WFN_VHUL:  w_fn = {i_v[7:4], i_u[3:0]};
      WFN_NOTU:  w_fn = ~i_u;
      default:   w_fn = ~i_u;
    endcase
  end

  always_comb begin
    w_hi = w_fn[7:4];
    case (i_ul)
      SRC_EMIX: w_hi = i_emix;
      SRC_U:    w_hi = i_u[7:4];
      SRC_V:    w_hi = i_v[7:4];
      default:  w_hi = w_fn[7:4];
    endcase
  end

  always_comb begin
    w_lo = w_fn[3:0];
    case (i_ur)
      SRC_EMIX: w_lo = i_emix;
      SRC_U:    w_lo = i_u[3:0];
      SRC_V:    w_lo = i_v[3:0];
      default:  w_lo = w_fn[3:0];
    endcase
  end

  assign o_w = {w_hi, w_lo};

  // Edit status flags V against blank (0x20) and the two fill/significance characters.
  assign o_stat[0] = (i_v != 8'h20) && (i_v != 8'h21);
  assign o_stat[1] = (i_v != 8'h20) && (i_v != 8'h22);

endmodule

// File: rtl/x2050mvw.sv
// x2050 mover with per-mode WFN function registers and a one-deep result register.
// Latency: 1 cycle from accepted operand to o_valid/o_w/o_edit_stat.
// Backpressure: o_ready = !o_valid | i_ready (full throughput); result held while i_ready low.
// Ports: i_clk/i_reset (async active-low); i_ros_advance/i_ss/i_e/i_mode load WFN;
//        i_ul/i_ur/i_amwp steer the mover; i_u/i_v with i_valid/o_ready in;
//        o_w/o_edit_stat with o_valid/i_ready out; o_wfn exposes every WFN register.
module x2050mvw
  import x2050_pkg::*;
#(
  parameter  int          LANES    = 1,
  parameter  int          NMODES   = 2,
  parameter  logic [31:0] FLIPMASK = 32'b10,
  localparam int          MW       = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ros_advance,
  input  logic [MW-1:0]         i_mode,
  input  logic [1:0]            i_ul,
  input  logic [1:0]            i_ur,
  input  logic [3:0]            i_e,
  input  logic [5:0]            i_ss,
  input  logic [3:0]            i_amwp,
  input  logic [8*LANES-1:0]    i_u,
  input  logic [8*LANES-1:0]    i_v,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [8*LANES-1:0]    o_w,
  output logic [2*LANES-1:0]    o_edit_stat,
  output logic [3*NMODES-1:0]   o_wfn
);

  localparam logic [MW:0] NMODES_W = NMODES[MW:0];

  logic [2:0]         r_wfn [NMODES];
  logic               r_valid;
  logic [8*LANES-1:0] r_w;
  logic [2*LANES-1:0] r_stat;

  logic               w_mode_ok;
  logic [2:0]         w_fn;
  logic               w_flip;
  logic [2:0]         w_wfn_new;
  logic               w_wfn_wr;
  logic               w_xfer;
  logic [3:0]         w_emix;
  logic [8*LANES-1:0] w_w;
  logic [2*LANES-1:0] w_stat;
  logic               w_unused;

  // Only the ASCII bit of AMWP matters to the mover.
  assign w_unused = ^i_amwp[2:0];

  // An out-of-range mode selects nothing: no transfer and no WFN write.
  assign w_mode_ok = ({1'b0, i_mode} < NMODES_W);

  always_comb begin
    w_fn   = 3'd0;
    w_flip = 1'b0;
    for (int m = 0; m < NMODES; m++) begin
      if (i_mode == MW'(m)) begin
        w_fn   = r_wfn[m];
        w_flip = FLIPMASK[m];
      end
    end
  end

  assign w_wfn_new = w_flip ? {i_e[0], i_e[1], i_e[2]} : i_e[2:0];
  assign w_wfn_wr  = i_ros_advance && (i_ss == SS_WFN) && w_mode_ok;

  assign o_ready = (!r_valid || i_ready) && w_mode_ok;
  assign w_xfer  = i_valid && o_ready;

  assign w_emix = e_mixin(i_e, i_amwp[AMWP_ASCII_BIT]);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    x2050mvlane u_lane (
      .i_u    (i_u[8*k +: 8]),
      .i_v    (i_v[8*k +: 8]),
      .i_fn   (w_fn),
      .i_ul   (i_ul),
      .i_ur   (i_ur),
      .i_emix (w_emix),
      .o_w    (w_w[8*k +: 8]),
      .o_stat (w_stat[2*k +: 2])
    );
  end

  // WFN registers; the mover reads w_fn from the pre-edge value, so a
  // same-cycle write and transfer uses the old function.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int m = 0; m < NMODES; m++) begin
        r_wfn[m] <= 3'd0;
      end
    end else begin
      for (int m = 0; m < NMODES; m++) begin
        if (w_wfn_wr && (i_mode == MW'(m))) begin
          r_wfn[m] <= w_wfn_new;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
      r_w     <= '0;
      r_stat  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_w     <= w_w;
      r_stat  <= w_stat;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_w         = r_w;
  assign o_edit_stat = r_stat;

  for (genvar m = 0; m < NMODES; m++) begin : g_wfn
    assign o_wfn[3*m +: 3] = r_wfn[m];
  end

endmodule
